// File: rtl/adc_avg_filter.sv
// Block-averaging filter for two ADS8363 converter pairs, with an optional offset
// calibration mode compiled in by defining ADC_OFFSET_CAL_EN.
module adc_avg_filter #(
  parameter int AVG_LOG2 = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        sample_vld,
  input  logic        sample_ch,
  input  logic [19:0] sample_a,
  input  logic [19:0] sample_b,
  input  logic        hold,
  input  logic        cal_start,
  output logic [15:0] data_a0,
  output logic [15:0] data_a1,
  output logic [15:0] data_b0,
  output logic [15:0] data_b1,
  output logic        data_upd,
  output logic        cal_busy
);

  localparam int AW = 16 + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic signed [AW-1:0] acc_a [2];
  logic signed [AW-1:0] acc_b [2];
  logic [CW-1:0]        cnt [2];
  logic signed [15:0]   out_a [2];
  logic signed [15:0]   out_b [2];
  logic signed [15:0]   pend_a [2];
  logic signed [15:0]   pend_b [2];
  logic [1:0]           pend_v;
  logic                 upd_r;

  logic                 sel;
  logic signed [15:0]   code_a, code_b;
  logic signed [AW-1:0] sum_a, sum_b, shr_a, shr_b;
  logic signed [15:0]   avg_a, avg_b, res_a, res_b;
  logic                 last, done;
  logic                 in_cal, cal_clear;
  logic                 unused_bits;

  assign sel    = sample_ch;
  assign code_a = sample_a[15:0];
  assign code_b = sample_b[15:0];
  assign sum_a  = acc_a[sel] + AW'(code_a);
  assign sum_b  = acc_b[sel] + AW'(code_b);
  assign shr_a  = sum_a >>> AVG_LOG2;
  assign shr_b  = sum_b >>> AVG_LOG2;
  assign avg_a  = shr_a[15:0];
  assign avg_b  = shr_b[15:0];
  assign last   = (AVG_LOG2 == 0) || (cnt[sel] == {CW{1'b1}});
  // A sample arriving together with a calibration start is discarded with the partial sums.
  assign done   = sample_vld && last && !cal_clear;

`ifdef ADC_OFFSET_CAL_EN
  typedef enum logic {RUN = 1'b0, CAL = 1'b1} state_t;
  state_t             state, state_nxt;
  logic [1:0]         cal_seen, cal_hit;
  logic signed [15:0] off_a [2];
  logic signed [15:0] off_b [2];

  function automatic logic signed [15:0] sat_sub(input logic signed [15:0] x,
                                                 input logic signed [15:0] y);
    logic signed [16:0] d;
    d = 17'(x) - 17'(y);
    if (d[16] != d[15]) sat_sub = d[16] ? 16'sh8000 : 16'sh7fff;
    else                sat_sub = d[15:0];
  endfunction

  assign in_cal    = (state == CAL);
  assign cal_clear = cal_start && (state == RUN);
  assign cal_hit   = (in_cal && done) ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign res_a     = sat_sub(avg_a, off_a[sel]);
  assign res_b     = sat_sub(avg_b, off_b[sel]);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= RUN;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: if (cal_start) state_nxt = CAL;
      CAL: if ((cal_seen | cal_hit) == 2'b11) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    cal_busy = (state == CAL);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cal_seen <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        off_a[p] <= '0;
        off_b[p] <= '0;
      end
    end else if (cal_clear) begin
      cal_seen <= 2'b00;
    end else if (in_cal) begin
      cal_seen <= cal_seen | cal_hit;
      if (done) begin
        off_a[sel] <= avg_a;
        off_b[sel] <= avg_b;
      end
    end
  end

  assign unused_bits = ^{sample_a[19:16], sample_b[19:16]};
`else
  assign in_cal      = 1'b0;
  assign cal_clear   = 1'b0;
  assign cal_busy    = 1'b0;
  assign res_a       = avg_a;
  assign res_b       = avg_b;
  assign unused_bits = ^{sample_a[19:16], sample_b[19:16], cal_start};
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      upd_r  <= 1'b0;
      pend_v <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        acc_a[p]  <= '0;
        acc_b[p]  <= '0;
        cnt[p]    <= '0;
        out_a[p]  <= '0;
        out_b[p]  <= '0;
        pend_a[p] <= '0;
        pend_b[p] <= '0;
      end
    end else begin
      upd_r <= 1'b0;
      if (cal_clear) begin
        for (int p = 0; p < 2; p++) begin
          acc_a[p] <= '0;
          acc_b[p] <= '0;
          cnt[p]   <= '0;
        end
      end else if (sample_vld) begin
        if (last) begin
          acc_a[sel] <= '0;
          acc_b[sel] <= '0;
          cnt[sel]   <= '0;
        end else begin
          acc_a[sel] <= sum_a;
          acc_b[sel] <= sum_b;
          cnt[sel]   <= cnt[sel] + CW'(1);
        end
      end
      if (!in_cal) begin
        if (hold) begin
          if (done) begin
            pend_a[sel] <= res_a;
            pend_b[sel] <= res_b;
            pend_v[sel] <= 1'b1;
          end
        end else begin
          // A completion in the release cycle is newer than anything pending.
          for (int p = 0; p < 2; p++) begin
            if (done && (sel == p[0])) begin
              out_a[p] <= res_a;
              out_b[p] <= res_b;
            end else if (pend_v[p]) begin
              out_a[p] <= pend_a[p];
              out_b[p] <= pend_b[p];
            end
          end
          pend_v <= 2'b00;
          upd_r  <= done || (pend_v != 2'b00);
        end
      end
    end
  end

  assign data_a0  = out_a[0];
  assign data_a1  = out_a[1];
  assign data_b0  = out_b[0];
  assign data_b1  = out_b[1];
  assign data_upd = upd_r;

endmodule
